// File: rtl/cgra_stream_tester_pkg.sv
// Shared types and constants for the CGRA pad stream tester.
// Config ROM entries pack {addr, data} into 64 bits.
package cgra_stream_tester_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConfig,
    StSettle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned SETTLE_CYCLES = 4;

  localparam int unsigned CFG_FIELD_W  = 32;
  localparam int unsigned CFG_ADDR_LSB = 32;
  localparam int unsigned CFG_DATA_LSB = 0;

  function automatic logic [CFG_FIELD_W-1:0] cfg_addr_field(input logic [63:0] entry);
    return entry[CFG_ADDR_LSB +: CFG_FIELD_W];
  endfunction

  function automatic logic [CFG_FIELD_W-1:0] cfg_data_field(input logic [63:0] entry);
    return entry[CFG_DATA_LSB +: CFG_FIELD_W];
  endfunction

endpackage

// File: rtl/cgra_delay_line.sv
// Fixed-depth shift register with a runtime tap; tap 0 passes the input straight through.
module cgra_delay_line #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [Width-1:0]           din_i,
  input  logic [$clog2(Depth+1)-1:0] tap_i,
  output logic [Width-1:0]           dout_o
);

  localparam int unsigned TapW = $clog2(Depth + 1);

  logic [Depth*Width-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_q <= '0;
    end else begin
      line_q[Width-1:0] <= din_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        line_q[i*Width +: Width] <= line_q[(i-1)*Width +: Width];
      end
    end
  end

  always_comb begin
    dout_o = din_i;
    for (int unsigned i = 1; i <= Depth; i++) begin
      if (tap_i == TapW'(i)) dout_o = line_q[(i-1)*Width +: Width];
    end
  end

endmodule

// File: rtl/cgra_stream_tester.sv
// Loads CGRA config from a ROM, streams counting patterns into the pads and checks the
// returned streams against a delayed, shifted copy of what was driven.
module cgra_stream_tester
  import cgra_stream_tester_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned LAT_MAX = 16,
  parameter int unsigned CFG_AW  = 10
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         start,
  input  logic [CFG_AW:0]              cfg_count,
  output logic [CFG_AW-1:0]            cfg_rd_addr,
  input  logic [63:0]                  cfg_rd_data,
  output logic [31:0]                  config_addr_out,
  output logic [31:0]                  config_data_out,
  input  logic [$clog2(LAT_MAX+1)-1:0] latency,
  input  logic [1:0]                   shift,
  input  logic [31:0]                  run_cycles,
  output logic [NUM_CH*DATA_W-1:0]     pad_drive,
  input  logic [NUM_CH*DATA_W-1:0]     pad_sense,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [15:0]                  err_count,
  output logic [1:0]                   first_err_ch
);

  localparam int unsigned LatW = $clog2(LAT_MAX + 1);

  state_e              state_q;
  logic [CFG_AW:0]     cfg_count_q;
  logic [31:0]         run_cycles_q;
  logic [31:0]         run_cnt_q;
  logic [LatW-1:0]     lat_q;
  logic [1:0]          shift_q;
  logic [2:0]          settle_cnt_q;
  // Read pipeline: issue -> ROM data valid -> output register holds entry.
  logic                iss_q, vld_q, vld_last_q, out_last_q;
  logic                iss_last;
  logic [LatW-1:0]     lat_clamped;

  logic [NUM_CH*DATA_W-1:0] delayed;
  logic [NUM_CH-1:0]        mismatch;
  logic                     check_en;
  logic [2:0]               n_err;
  logic [1:0]               first_ch;
  logic [16:0]              err_sum;
  logic [15:0]              err_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cgra_delay_line #(
      .Width(DATA_W),
      .Depth(LAT_MAX)
    ) u_delay (
      .clk_i  (clk_in),
      .reset_i(reset_in),
      .din_i  (pad_drive[c*DATA_W +: DATA_W]),
      .tap_i  (lat_q),
      .dout_o (delayed[c*DATA_W +: DATA_W])
    );
  end

  assign lat_clamped = (32'(latency) > LAT_MAX) ? LatW'(LAT_MAX) : latency;
  assign iss_last    = iss_q && ({1'b0, cfg_rd_addr} == cfg_count_q - 1'b1);
  assign check_en    = (state_q == StRun) && (run_cnt_q >= 32'(lat_q));

  always_comb begin
    mismatch = '0;
    n_err    = '0;
    first_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      mismatch[c] = pad_sense[c*DATA_W +: DATA_W] != (delayed[c*DATA_W +: DATA_W] << shift_q);
      if (mismatch[c]) begin
        n_err    = n_err + 3'd1;
        first_ch = 2'(c);
      end
    end
    err_sum = {1'b0, err_count} + 17'(n_err);
    err_d   = err_count;
    if (check_en) err_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q         <= StIdle;
      cfg_count_q     <= '0;
      run_cycles_q    <= '0;
      run_cnt_q       <= '0;
      lat_q           <= '0;
      shift_q         <= '0;
      settle_cnt_q    <= '0;
      iss_q           <= 1'b0;
      vld_q           <= 1'b0;
      vld_last_q      <= 1'b0;
      out_last_q      <= 1'b0;
      cfg_rd_addr     <= '0;
      config_addr_out <= '0;
      config_data_out <= '0;
      pad_drive       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_ch    <= '0;
    end else begin
      vld_q      <= iss_q;
      vld_last_q <= iss_last;
      out_last_q <= vld_last_q;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cfg_count_q  <= cfg_count;
            run_cycles_q <= run_cycles;
            lat_q        <= lat_clamped;
            shift_q      <= shift;
            settle_cnt_q <= '0;
            err_count    <= '0;
            first_err_ch <= '0;
            pass         <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b1;
            if (cfg_count != '0) begin
              state_q     <= StConfig;
              iss_q       <= 1'b1;
              cfg_rd_addr <= '0;
            end else begin
              state_q <= StSettle;
            end
          end
        end
        StConfig: begin
          if (iss_q) begin
            if (iss_last) begin
              iss_q       <= 1'b0;
              cfg_rd_addr <= '0;
            end else begin
              cfg_rd_addr <= cfg_rd_addr + 1'b1;
            end
          end
          config_addr_out <= vld_q ? cfg_addr_field(cfg_rd_data) : '0;
          config_data_out <= vld_q ? cfg_data_field(cfg_rd_data) : '0;
          if (out_last_q) state_q <= StSettle;
        end
        StSettle: begin
          if (settle_cnt_q == 3'(SETTLE_CYCLES - 1)) begin
            if (run_cycles_q == '0) begin
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (err_count == '0);
            end else begin
              state_q   <= StRun;
              run_cnt_q <= '0;
              for (int unsigned c = 0; c < NUM_CH; c++) begin
                pad_drive[c*DATA_W +: DATA_W] <= DATA_W'(c);
              end
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + 3'd1;
          end
        end
        StRun: begin
          err_count <= err_d;
          // err_count stays nonzero once set, so zero marks "no mismatch seen yet".
          if (check_en && (mismatch != '0) && (err_count == '0)) first_err_ch <= first_ch;
          run_cnt_q <= run_cnt_q + 32'd1;
          if (run_cnt_q == run_cycles_q - 32'd1) begin
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_d == '0);
            pad_drive <= '0;
          end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              pad_drive[c*DATA_W +: DATA_W] <= pad_drive[c*DATA_W +: DATA_W] + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_stream_tester.sv
// Self-checking bench: behavioural CGRA stand-in plus an arithmetic reference for error counts.
module tb_cgra_stream_tester;

  localparam int DATA_W  = 16;
  localparam int NUM_CH  = 4;
  localparam int LAT_MAX = 16;
  localparam int CFG_AW  = 10;
  localparam int LW      = $clog2(LAT_MAX + 1);

  logic                     clk_in = 1'b0;
  logic                     reset_in;
  logic                     start;
  logic [CFG_AW:0]          cfg_count;
  logic [CFG_AW-1:0]        cfg_rd_addr;
  logic [63:0]              cfg_rd_data;
  logic [31:0]              config_addr_out, config_data_out;
  logic [LW-1:0]            latency;
  logic [1:0]               shift;
  logic [31:0]              run_cycles;
  logic [NUM_CH*DATA_W-1:0] pad_drive, pad_sense;
  logic                     busy, done, pass;
  logic [15:0]              err_count;
  logic [1:0]               first_err_ch;

  int checks = 0;
  int errors = 0;

  // CGRA stand-in: pads delayed by cg_lat cycles, shifted left by cg_shift.
  logic [4:0]               cg_lat = '0;
  logic [1:0]               cg_shift = '0;
  logic                     cg_invert = 1'b0;
  logic                     fault = 1'b0;
  logic [NUM_CH*DATA_W-1:0] hist [32];
  logic [NUM_CH*DATA_W-1:0] src;
  logic [63:0]              rom [16];

  cgra_stream_tester #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .LAT_MAX(LAT_MAX),
    .CFG_AW (CFG_AW)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .start          (start),
    .cfg_count      (cfg_count),
    .cfg_rd_addr    (cfg_rd_addr),
    .cfg_rd_data    (cfg_rd_data),
    .config_addr_out(config_addr_out),
    .config_data_out(config_data_out),
    .latency        (latency),
    .shift          (shift),
    .run_cycles     (run_cycles),
    .pad_drive      (pad_drive),
    .pad_sense      (pad_sense),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_ch   (first_err_ch)
  );

  always #5 clk_in = ~clk_in;

  always_ff @(posedge clk_in) begin
    cfg_rd_data <= rom[cfg_rd_addr[3:0]];
    hist[0]     <= pad_drive;
    for (int i = 1; i < 32; i++) hist[i] <= hist[i-1];
  end

  always_comb begin
    src = (cg_lat == 5'd0) ? pad_drive : hist[cg_lat - 5'd1];
    pad_sense = '0;
    for (int c = 0; c < NUM_CH; c++) pad_sense[c*DATA_W +: DATA_W] = src[c*DATA_W +: DATA_W] << cg_shift;
    if (cg_invert) pad_sense = ~pad_sense;
    if (fault) pad_sense[DATA_W] = 1'b1;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: RUN cycle k drives c+k on channel c; the check at k >= lat compares the
  // stand-in's output against (c + k - lat) << sh, all modulo 2^16.
  task automatic predict(input int lat, input int sh, input int clat, input int csh,
                         input bit inv, input int rc, output int exp_err, output int exp_first);
    int le, e, s;
    exp_err = 0;
    exp_first = 0;
    le = (lat > LAT_MAX) ? LAT_MAX : lat;
    for (int k = le; k < rc; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e = ((c + k - le) << sh) & 32'hFFFF;
        s = (k >= clat) ? (((c + k - clat) << csh) & 32'hFFFF) : 0;
        if (inv) s = s ^ 32'hFFFF;
        if (e != s) begin
          if (exp_err == 0) exp_first = c;
          if (exp_err < 65535) exp_err++;
        end
      end
    end
  endtask

  task automatic run_and_check(input string name, input int n_cfg, input int lat, input int sh,
                               input int rc, input int exp_err, input int exp_first,
                               input int fault_k);
    int pre, n, lim;
    logic [63:0] ent;
    logic [15:0] want;
    pre = ((n_cfg > 0) ? n_cfg + 2 : 0) + 5;
    lim = pre + rc + 50;
    cfg_count = (CFG_AW+1)'(n_cfg);
    latency = LW'(lat);
    shift = 2'(sh);
    run_cycles = 32'(rc);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    checks++;
    if (err_count !== 16'd0 || pass !== 1'b0 || first_err_ch !== 2'd0) begin
      errors++;
      $display("FAIL %s clear-on-start: err=%0d pass=%b first=%0d, want 0/0/0", name,
               err_count, pass, first_err_ch);
    end
    while (!done && n < lim) begin
      if (n <= n_cfg) begin
        checks++;
        if (cfg_rd_addr !== CFG_AW'(n - 1)) begin
          errors++;
          $display("FAIL %s cfg_rd_addr cycle %0d: got %0d want %0d", name, n, cfg_rd_addr, n - 1);
        end
      end
      if (n < pre) begin
        ent = (n >= 3 && n <= n_cfg + 2) ? rom[n-3] : 64'd0;
        checks++;
        if ({config_addr_out, config_data_out} !== ent) begin
          errors++;
          $display("FAIL %s config out cycle %0d: got %h_%h want %h", name, n, config_addr_out,
                   config_data_out, ent);
        end
        checks++;
        if (pad_drive !== '0) begin
          errors++;
          $display("FAIL %s pad_drive before RUN cycle %0d: got %h want 0", name, n, pad_drive);
        end
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          want = 16'(c + n - pre);
          checks++;
          if (pad_drive[c*DATA_W +: DATA_W] !== want) begin
            errors++;
            $display("FAIL %s pad_drive ch%0d RUN %0d: got %h want %h", name, c, n - pre,
                     pad_drive[c*DATA_W +: DATA_W], want);
          end
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, n, busy);
      end
      fault = (fault_k >= 0) && (n == pre + fault_k);
      tick();
      n++;
    end
    fault = 1'b0;
    checks++;
    if (done !== 1'b1 || n != pre + rc) begin
      errors++;
      $display("FAIL %s done timing: done=%b at cycle %0d, want 1 at %0d", name, done, n, pre + rc);
    end
    checks++;
    if (err_count !== 16'(exp_err)) begin
      errors++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_count, exp_err);
    end
    checks++;
    if (first_err_ch !== 2'(exp_first)) begin
      errors++;
      $display("FAIL %s first_err_ch: got %0d want %0d", name, first_err_ch, exp_first);
    end
    checks++;
    if (pass !== (exp_err == 0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s pass/busy: got %b/%b want %b/0", name, pass, busy, exp_err == 0);
    end
    repeat (20) tick();
    checks++;
    if (done !== 1'b1 || pass !== (exp_err == 0) || err_count !== 16'(exp_err)) begin
      errors++;
      $display("FAIL %s DONE hold: done=%b pass=%b err=%0d", name, done, pass, err_count);
    end
  endtask

  task automatic set_cgra(input int clat, input int csh, input bit inv);
    cg_lat = 5'(clat);
    cg_shift = 2'(csh);
    cg_invert = inv;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (20) tick();
    reset_in = 1'b0;
    tick();
    checks++;
    if ({busy, done, pass, err_count, first_err_ch} !== '0 || pad_drive !== '0 ||
        config_addr_out !== '0 || config_data_out !== '0 || cfg_rd_addr !== '0) begin
      errors++;
      $display("FAIL reset values: busy=%b done=%b pass=%b err=%0d drive=%h cfg=%h/%h addr=%0d",
               busy, done, pass, err_count, pad_drive, config_addr_out, config_data_out,
               cfg_rd_addr);
    end
  endtask

  task automatic test_loopback();
    set_cgra(0, 0, 1'b0);
    run_and_check("loopback", 0, 0, 0, 100, 0, 0, -1);
  endtask

  task automatic test_config();
    set_cgra(0, 0, 1'b0);
    for (int i = 0; i < 16; i++) rom[i] = {$urandom, $urandom};
    run_and_check("config3", 3, 0, 0, 10, 0, 0, -1);
    run_and_check("run_zero", 0, 2, 0, 0, 0, 0, -1);
  endtask

  task automatic test_random();
    int clat, csh, lat, sh, rc, ncfg, ee, ef;
    for (int it = 0; it < 8; it++) begin
      clat = $urandom_range(0, 16);
      csh = $urandom_range(0, 3);
      ncfg = $urandom_range(0, 5);
      rc = (it == 0) ? 0 : $urandom_range(1, 60);
      if ($urandom_range(0, 1) == 1) begin
        lat = (clat == 16) ? $urandom_range(16, 31) : clat;
        sh = csh;
      end else begin
        lat = $urandom_range(0, 31);
        sh = $urandom_range(0, 3);
      end
      for (int i = 0; i < 16; i++) rom[i] = {$urandom, $urandom};
      set_cgra(clat, csh, 1'b0);
      predict(lat, sh, clat, csh, 1'b0, rc, ee, ef);
      run_and_check($sformatf("rand%0d", it), ncfg, lat, sh, rc, ee, ef, -1);
    end
  endtask

  task automatic test_fault();
    set_cgra(3, 1, 1'b0);
    run_and_check("fault", 0, 3, 1, 200, 1, 1, 100);
  endtask

  task automatic test_wrap();
    int ee, ef;
    set_cgra(3, 1, 1'b0);
    predict(3, 1, 3, 1, 1'b0, 65545, ee, ef);
    run_and_check("wrap", 0, 3, 1, 65545, ee, ef, -1);
  endtask

  task automatic test_saturate();
    int ee, ef;
    set_cgra(0, 0, 1'b1);
    predict(0, 0, 0, 0, 1'b1, 16400, ee, ef);
    run_and_check("saturate", 0, 0, 0, 16400, ee, ef, -1);
    set_cgra(0, 0, 1'b0);
    repeat (20) tick();
  endtask

  task automatic test_reset_mid_run();
    set_cgra(0, 0, 1'b1);
    cfg_count = '0;
    latency = '0;
    shift = '0;
    run_cycles = 32'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n < 55; n++) begin
      start = (n == 15);
      tick();
    end
    checks++;
    if (pad_drive[DATA_W-1:0] !== 16'd50 || busy !== 1'b1 || err_count !== 16'd200) begin
      errors++;
      $display("FAIL restart ignored: ch0=%0d busy=%b err=%0d want 50/1/200",
               pad_drive[DATA_W-1:0], busy, err_count);
    end
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    checks++;
    if ({busy, done, pass, err_count, first_err_ch} !== '0 || pad_drive !== '0 ||
        config_addr_out !== '0 || config_data_out !== '0 || cfg_rd_addr !== '0) begin
      errors++;
      $display("FAIL mid-run reset: busy=%b done=%b err=%0d drive=%h", busy, done, err_count,
               pad_drive);
    end
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pad_drive !== '0) begin
      errors++;
      $display("FAIL idle after reset: busy=%b done=%b drive=%h", busy, done, pad_drive);
    end
    set_cgra(0, 0, 1'b0);
    repeat (20) tick();
  endtask

  initial begin
    reset_in = 1'b1;
    start = 1'b0;
    cfg_count = '0;
    latency = '0;
    shift = '0;
    run_cycles = '0;
    for (int i = 0; i < 16; i++) rom[i] = 64'd0;
    test_reset();
    test_loopback();
    test_config();
    test_random();
    test_fault();
    test_reset_mid_run();
    test_wrap();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
